// File: rtl/ysyx_23060236_rd_arbiter_pkg.sv
// rtl/ysyx_23060236_rd_arbiter_pkg.sv - shared encodings and constants for the read-channel arbiter
package ysyx_23060236_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    typedef enum logic {
        GNT_IFU = 1'b0,
        GNT_LSU = 1'b1
    } grant_e;

    // IFU always fetches full 32-bit words; LSU loads are always single INCR beats.
    localparam logic [2:0] IFU_ARSIZE = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/ysyx_23060236_arb_pick.sv
// rtl/ysyx_23060236_arb_pick.sv - winner select between IFU and LSU; ARB_ROUND_ROBIN_EN selects round-robin ties
module ysyx_23060236_arb_pick
    import ysyx_23060236_rd_arbiter_pkg::*;
(
    input  logic   ifu_req_i,
    input  logic   lsu_req_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  grant_e last_grant_i,
`endif
    output logic   valid_o,
    output grant_e grant_o
);

    // A lone requester always wins; only a tie consults the tie-break rule.
    always_comb begin
        valid_o = ifu_req_i | lsu_req_i;
        grant_o = GNT_LSU;
        if (ifu_req_i && lsu_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_o = (last_grant_i == GNT_IFU) ? GNT_LSU : GNT_IFU;
`else
            grant_o = GNT_LSU;
`endif
        end else if (ifu_req_i) begin
            grant_o = GNT_IFU;
        end
    end

endmodule

// File: rtl/ysyx_23060236_rd_arbiter.sv
// rtl/ysyx_23060236_rd_arbiter.sv - AXI4 read-port arbiter between IFU bursts and LSU loads; ARB_ROUND_ROBIN_EN enables round-robin ties
module ysyx_23060236_rd_arbiter
    import ysyx_23060236_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic [7:0]        ifu_arlen,
    input  logic [1:0]        ifu_arburst,
    output logic              ifu_rvalid,
    input  logic              ifu_rready,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic [1:0]        ifu_rresp,
    output logic              ifu_rlast,

    input  logic              lsu_arvalid,
    output logic              lsu_arready,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic [2:0]        lsu_arsize,
    output logic              lsu_rvalid,
    input  logic              lsu_rready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic [1:0]        lsu_rresp,

    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,

    output logic              arb_err
);

    state_e              state_q;
    grant_e              grant_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          len_q;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    logic [7:0]          cnt_q;
    logic                err_q;
    logic                arvalid_q;

    logic                pick_valid;
    grant_e              pick_grant;
    logic                in_idle;
    logic                in_data;
    logic                r_hs;

`ifdef ARB_ROUND_ROBIN_EN
    grant_e              last_grant_q;
`endif

    ysyx_23060236_arb_pick u_pick (
        .ifu_req_i    (ifu_arvalid),
        .lsu_req_i    (lsu_arvalid),
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant_i (last_grant_q),
`endif
        .valid_o      (pick_valid),
        .grant_o      (pick_grant)
    );

    assign in_idle = (state_q == ST_IDLE);
    assign in_data = (state_q == ST_DATA);

    // The grant is offered in the same IDLE cycle the request is seen; reset
    // masks it so nothing is accepted while reset is held.
    assign ifu_arready = in_idle && !reset && pick_valid && (pick_grant == GNT_IFU);
    assign lsu_arready = in_idle && !reset && pick_valid && (pick_grant == GNT_LSU);

    assign m_arvalid = arvalid_q;
    assign m_araddr  = addr_q;
    assign m_arlen   = len_q;
    assign m_arsize  = size_q;
    assign m_arburst = burst_q;

    // R channel is a pure pass-through steered by the latched grant.
    assign m_rready   = in_data && ((grant_q == GNT_LSU) ? lsu_rready : ifu_rready);
    assign ifu_rvalid = in_data && (grant_q == GNT_IFU) && m_rvalid;
    assign lsu_rvalid = in_data && (grant_q == GNT_LSU) && m_rvalid;
    assign ifu_rdata  = m_rdata;
    assign lsu_rdata  = m_rdata;
    assign ifu_rresp  = m_rresp;
    assign lsu_rresp  = m_rresp;
    assign ifu_rlast  = ifu_rvalid && m_rlast;

    assign r_hs    = in_data && m_rvalid && m_rready;
    assign arb_err = err_q;

    // Arbiter FSM: latch the winner's AR fields, issue AR, then count R beats until rlast.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= GNT_LSU;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            arvalid_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= GNT_LSU;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_q   <= pick_grant;
                        cnt_q     <= '0;
                        arvalid_q <= 1'b1;
                        state_q   <= ST_ADDR;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_q <= pick_grant;
`endif
                        if (pick_grant == GNT_LSU) begin
                            addr_q  <= lsu_araddr;
                            len_q   <= 8'd0;
                            size_q  <= lsu_arsize;
                            burst_q <= BURST_INCR;
                        end else begin
                            addr_q  <= ifu_araddr;
                            len_q   <= ifu_arlen;
                            size_q  <= IFU_ARSIZE;
                            burst_q <= ifu_arburst;
                        end
                    end
                end
                ST_ADDR: begin
                    if (m_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_hs) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (m_rlast) begin
                            state_q <= ST_IDLE;
                            // cnt_q is the index of the beat just taken; the last must be index len.
                            if (cnt_q != len_q) begin
                                err_q <= 1'b1;
                            end
                        end else if (cnt_q == len_q) begin
                            // Final expected beat came without rlast; keep waiting for it.
                            err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
